// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM encoding, iteration count and result bundle.
package alu_pkg;
  localparam int          DW            = 32;
  localparam logic [1:0]  S_IDLE        = 2'b00;
  localparam logic [1:0]  S_RUN         = 2'b01;
  localparam logic [1:0]  S_DONE        = 2'b10;
  localparam int          DIV_ITER      = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          div_by_zero;
  } div_res_t;
endpackage

// File: rtl/fastSubtractor.sv
// Shared combinational 32-bit subtractor: s = a - b, c = 1 when no borrow.
module fastSubtractor
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] s,
  output logic          c,
  output logic          ov
);
  assign {c, s} = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
  // Signed overflow: operands differ in sign and the result sign flips from a.
  assign ov = (a[DW-1] ^ b[DW-1]) & (s[DW-1] ^ a[DW-1]);
endmodule

// File: rtl/seq_divider_ctrl.sv
// Multi-cycle unsigned 32-bit restoring divider, one trial subtraction per clock
// through the shared fastSubtractor; start/done handshake with held results.
module seq_divider_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero
);
  localparam logic [4:0] CNT_LAST = 5'(DIV_ITER - 1);

  logic [1:0]    state;
  logic [4:0]    cnt;
  logic [DW-1:0] q_r, r_r, d_r;
  div_res_t      res;

  logic [DW-1:0] shifted, sub_s, r_nxt, q_nxt;
  logic          sub_c, sub_ov_unused, q_bit;

  assign shifted = {r_r[DW-2:0], q_r[DW-1]};

  fastSubtractor u_sub (
    .a  (shifted),
    .b  (d_r),
    .s  (sub_s),
    .c  (sub_c),
    .ov (sub_ov_unused)
  );

  // R[31] set means the true 33-bit shifted value already exceeds D,
  // and the low 32 bits of the difference are still the right remainder.
  assign q_bit = r_r[DW-1] | sub_c;
  assign r_nxt = q_bit ? sub_s : shifted;
  assign q_nxt = {q_r[DW-2:0], q_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
      res   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          q_r <= dividend;
          r_r <= '0;
          d_r <= divisor;
          cnt <= '0;
          if (divisor == '0) begin
            state <= S_DONE;
            res   <= '{quotient: DIV0_QUOTIENT, remainder: dividend, div_by_zero: 1'b1};
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          r_r <= r_nxt;
          q_r <= q_nxt;
          cnt <= cnt + 5'd1;  // wraps to 0 on the last iteration
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            res   <= '{quotient: q_nxt, remainder: r_nxt, div_by_zero: 1'b0};
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready       = (state == S_IDLE);
  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign quotient    = res.quotient;
  assign remainder   = res.remainder;
  assign div_by_zero = res.div_by_zero;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Scoreboard bench for seq_divider_ctrl: directed vectors, ignored starts,
// mid-run reset and random operands checked against / and %.
module tb_seq_divider_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        ready, busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bcnt = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          nbusy;
    int          acc;
  } exp_t;
  exp_t sb[$];

  seq_divider_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) bcnt = 0;
    else if (busy) bcnt++;
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("busy_cycles", 32'(bcnt), 32'(e.nbusy));
      end
      bcnt = 0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    dividend = a; divisor = b; start = 1'b1;
    e.q = q; e.r = r; e.dz = (b == 0);
    e.lat = (b == 0) ? 1 : 33;
    e.nbusy = (b == 0) ? 0 : 32;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=pending required=empty");
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic [31:0] va [6] = '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1234};
  logic [31:0] vb [6] = '{32'd7, 32'd10, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] vq [6] = '{32'd14, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF};
  logic [31:0] vr [6] = '{32'd2, 32'd5, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd1234};

  initial begin
    logic [31:0] a, b;
    int n;
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vq[i], vr[i]);
      drain();
    end

    // start during RUN and during DONE must be ignored
    issue(32'd100, 32'd7, 32'd14, 32'd2);
    repeat (5) @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("reached_done", {31'd0, done}, 32'd1);
    dividend = 32'd50; divisor = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignored_ready", {31'd0, ready}, 32'd1);
    chk("held_quotient", quotient, 32'd14);
    chk("held_remainder", remainder, 32'd2);
    chk("held_dz", {31'd0, div_by_zero}, 32'd0);
    drain();
    issue(32'd50, 32'd5, 32'd10, 32'd0);
    drain();

    // asynchronous reset in the middle of RUN
    issue(32'd100, 32'd7, 32'd14, 32'd2);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dz", {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd100, 32'd7, 32'd14, 32'd2);
    drain();

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(2))
        0: b = $urandom_range(255);
        1: b = $urandom;
        default: b = $urandom >> $urandom_range(31);
      endcase
      if ($urandom_range(99) < 5) b = '0;
      issue(a, b, (b == 0) ? 32'hFFFF_FFFF : a / b, (b == 0) ? a : a % b);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
